// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector
// Flags every occurrence of a LEN-bit pattern in a registered serial bit
// stream and keeps a saturating count of matches.
//
// Build option: define SERIAL_PATTERN_OVERLAP_EN to let matches overlap.
// Without it, each match restarts the fill so the next match needs LEN
// fresh valid bits.
module serial_pattern_detector #(
    parameter logic [15:0] PATTERN = 16'b1011, // MSB of PATTERN[LEN-1:0] is the oldest bit
    parameter int          LEN     = 4,        // 2..16
    parameter int          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             count_clr,
    output logic             detect,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int FILL_W = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
    localparam logic [LEN-1:0]    PAT       = PATTERN[LEN-1:0];
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_ARMED = 1'b1;

    logic [LEN-1:0]    shreg;
    logic [LEN-1:0]    shreg_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;
    logic [0:0]        state;
    logic              hit;

    // Post-shift view of the window and fill; a hit needs a full window.
    always_comb begin
        shreg_nxt = {shreg[LEN-2:0], din};
        fill_inc  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit       = din_valid && (fill_inc == FILL_FULL) && (shreg_nxt == PAT);
    end

    // Shift register only advances on valid bits; gaps hold the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (din_valid) begin
            shreg <= shreg_nxt;
        end
    end

    // Fill counter and FILL/ARMED state; armed iff the fill has reached LEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill  <= '0;
            state <= S_FILL;
        end else if (din_valid) begin
`ifdef SERIAL_PATTERN_OVERLAP_EN
            fill  <= fill_inc;
            state <= (fill_inc == FILL_FULL) ? S_ARMED : S_FILL;
`else
            if (hit) begin
                // Window contents stay, but a fresh LEN bits are required.
                fill  <= '0;
                state <= S_FILL;
            end else begin
                fill  <= fill_inc;
                state <= (fill_inc == FILL_FULL) ? S_ARMED : S_FILL;
            end
`endif
        end
    end

    // One-cycle match pulse following the edge that shifted in the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            detect <= 1'b0;
        end else begin
            detect <= hit;
        end
    end

    // Saturating match counter; clear wins over a coincident match.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (count_clr) begin
            match_count <= '0;
        end else if (hit && (match_count != CNT_MAX)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

    assign armed = (state == S_ARMED);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Testbench for serial_pattern_detector: two instances (CNT_W=8 and CNT_W=2)
// share the stimulus and are checked every cycle against a bit-history model.
module tb_serial_pattern_detector;

    localparam logic [15:0] PAT = 16'b1011;
    localparam int          LEN = 4;

    logic       clk = 1'b0;
    logic       reset, din, din_valid, count_clr;
    logic       detect, armed, detect2, armed2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit   hist[$];
    int   nbits;
    logic exp_det, exp_armed;
    int   exp_cnt, exp_cnt2;

    always #5 clk = ~clk;

    serial_pattern_detector #(.PATTERN(PAT), .LEN(LEN), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .count_clr(count_clr), .detect(detect), .match_count(match_count),
        .armed(armed));

    serial_pattern_detector #(.PATTERN(PAT), .LEN(LEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .count_clr(count_clr), .detect(detect2), .match_count(match_count2),
        .armed(armed2));

    // Model: keep the valid bits seen, count bits since restart, compare the
    // most recent LEN bits as a number against the pattern.
    task automatic model_edge(input bit r, input bit d, input bit v, input bit c);
        bit m;
        int val;
        m = 1'b0;
        if (r) begin
            hist.delete();
            nbits = 0; exp_det = 1'b0; exp_cnt = 0; exp_cnt2 = 0;
            exp_armed = 1'b0;
            return;
        end
        if (v) begin
            hist.push_back(d);
            if (hist.size() > 32) void'(hist.pop_front());
            nbits++;
            if (nbits >= LEN) begin
                val = 0;
                for (int i = 0; i < LEN; i++) val = val * 2 + int'(hist[hist.size() - LEN + i]);
                m = (val == int'(PAT[LEN-1:0]));
            end
`ifndef SERIAL_PATTERN_OVERLAP_EN
            if (m) nbits = 0;
`endif
            if (nbits > LEN) nbits = LEN;
        end
        exp_det = m;
        if (c) begin
            exp_cnt = 0; exp_cnt2 = 0;
        end else if (m) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
        exp_armed = (nbits >= LEN);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic cyc(input bit r, input bit d, input bit v, input bit c);
        @(negedge clk);
        reset = r; din = d; din_valid = v; count_clr = c;
        @(posedge clk);
        model_edge(r, d, v, c);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 2) cyc(1, 0, 0, 0); else cyc(0, 1, 0, 0);
            checks++;
            if ({detect, armed, match_count, detect2, armed2, match_count2} !== 12'h0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got det=%b arm=%b cnt=%0d cnt2=%0d, want all 0",
                         i, detect, armed, match_count, match_count2);
            end
        end
    endtask

    task automatic test_single();
        bit [3:0] s = 4'b1011;
        cyc(1, 0, 0, 0);
        for (int i = 3; i >= 0; i--) begin
            cyc(0, s[i], 1, 0);
            checks++;
            if ({detect, armed, match_count, match_count2} !== {exp_det, exp_armed, exp_cnt[7:0], exp_cnt2[1:0]}) begin
                errors++;
                $display("FAIL single bit%0d: got det=%b arm=%b cnt=%0d cnt2=%0d, want det=%b arm=%b cnt=%0d cnt2=%0d",
                         3 - i, detect, armed, match_count, match_count2, exp_det, exp_armed, exp_cnt, exp_cnt2);
            end
        end
        checks++;
        if (detect !== 1'b1 || match_count !== 8'd1) begin
            errors++;
            $display("FAIL single_final: got det=%b cnt=%0d, want det=1 cnt=1", detect, match_count);
        end
        cyc(0, 0, 0, 0);
        checks++;
        if (detect !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got det=%b, want 0", detect);
        end
    endtask

    task automatic test_overlap();
        bit [6:0] s = 7'b1011011;
        cyc(1, 0, 0, 0);
        for (int i = 6; i >= 0; i--) begin
            cyc(0, s[i], 1, 0);
            checks++;
            if ({detect, armed, match_count, match_count2} !== {exp_det, exp_armed, exp_cnt[7:0], exp_cnt2[1:0]}) begin
                errors++;
                $display("FAIL overlap bit%0d: got det=%b arm=%b cnt=%0d, want det=%b arm=%b cnt=%0d",
                         7 - i, detect, armed, match_count, exp_det, exp_armed, exp_cnt);
            end
        end
        checks++;
`ifdef SERIAL_PATTERN_OVERLAP_EN
        if (match_count !== 8'd2) begin
            errors++;
            $display("FAIL overlap_count: got %0d, want 2", match_count);
        end
`else
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL overlap_count: got %0d, want 1", match_count);
        end
`endif
    endtask

    task automatic test_gaps_reset();
        // {reset, din, valid}
        bit [2:0] seq[13] = '{3'b110, 3'b011, 3'b001, 3'b000, 3'b010, 3'b000,
                              3'b011, 3'b011, 3'b011, 3'b001, 3'b011, 3'b100, 3'b011};
        for (int i = 0; i < 13; i++) begin
            cyc(seq[i][2], seq[i][1], seq[i][0], 0);
            checks++;
            if ({detect, armed, match_count, match_count2} !== {exp_det, exp_armed, exp_cnt[7:0], exp_cnt2[1:0]}) begin
                errors++;
                $display("FAIL gaps step%0d: got det=%b arm=%b cnt=%0d, want det=%b arm=%b cnt=%0d",
                         i, detect, armed, match_count, exp_det, exp_armed, exp_cnt);
            end
        end
        checks++;
        if (match_count !== 8'd0 || detect !== 1'b0) begin
            errors++;
            $display("FAIL gaps_after_reset: got det=%b cnt=%0d, want det=0 cnt=0", detect, match_count);
        end
    endtask

    task automatic test_saturation();
        bit [3:0] s = 4'b1011;
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 3; i >= 0; i--) begin
                cyc(0, s[i], 1, (k == 5 && i == 0));
                checks++;
                if ({detect, armed, match_count, match_count2} !== {exp_det, exp_armed, exp_cnt[7:0], exp_cnt2[1:0]}) begin
                    errors++;
                    $display("FAIL saturation m%0d b%0d: got det=%b cnt=%0d cnt2=%0d, want det=%b cnt=%0d cnt2=%0d",
                             k, 3 - i, detect, match_count, match_count2, exp_det, exp_cnt, exp_cnt2);
                end
            end
            if (k == 4) begin
                checks++;
                if (match_count2 !== 2'd3 || match_count !== 8'd5) begin
                    errors++;
                    $display("FAIL saturation_hold: got cnt2=%0d cnt=%0d, want cnt2=3 cnt=5", match_count2, match_count);
                end
            end
        end
        checks++;
        if (detect2 !== 1'b1 || match_count2 !== 2'd0) begin
            errors++;
            $display("FAIL clear_priority: got det=%b cnt2=%0d, want det=1 cnt2=0", detect2, match_count2);
        end
    endtask

    task automatic test_alternating();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, i[0], 1, 0);
            checks++;
            if ({detect, armed, match_count} !== {1'b0, (i >= 3), 8'd0}) begin
                errors++;
                $display("FAIL alternating bit%0d: got det=%b arm=%b cnt=%0d, want det=0 arm=%b cnt=0",
                         i, detect, armed, match_count, (i >= 3));
            end
        end
    endtask

    task automatic test_random();
        bit r, d, v, c;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            c = ($urandom_range(0, 59) == 0);
            cyc(r, d, v, c);
            checks++;
            if ({detect, armed, match_count, detect2, armed2, match_count2} !==
                {exp_det, exp_armed, exp_cnt[7:0], exp_det, exp_armed, exp_cnt2[1:0]}) begin
                errors++;
                $display("FAIL random cyc%0d: got det=%b arm=%b cnt=%0d cnt2=%0d, want det=%b arm=%b cnt=%0d cnt2=%0d",
                         i, detect, armed, match_count, match_count2, exp_det, exp_armed, exp_cnt, exp_cnt2);
            end
        end
    endtask

    initial begin
        reset = 1'b1; din = 1'b0; din_valid = 1'b0; count_clr = 1'b0;
        nbits = 0; exp_det = 1'b0; exp_armed = 1'b0; exp_cnt = 0; exp_cnt2 = 0;
        test_reset();
        test_single();
        test_overlap();
        test_gaps_reset();
        test_saturation();
        test_alternating();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
